// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal shift register with parallel load, rotate option, serial
//   in/out at both ends, and a saturating count of shifts performed since
//   the last load or reset.
//
// Parameters
//   WIDTH      register width in bits (2..64)
//   RESET_VAL  value loaded into Q on reset
//
// Ports
//   Clk     in   single clock, rising edge
//   Resetn  in   synchronous active-low reset (highest priority)
//   En      in   clock enable; 0 holds all state
//   Mode    in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   Rot     in   1 = shifts rotate end-around instead of taking serial-in
//   SinL    in   serial-in entering the MSB on a right shift
//   SinR    in   serial-in entering the LSB on a left shift
//   D       in   parallel load data
//   Q       out  register contents
//   SoutR   out  Q[0]
//   SoutL   out  Q[WIDTH-1]
//   Cnt     out  shifts since last load/reset, saturating at WIDTH
//   Done    out  Cnt == WIDTH
module univ_shift_reg #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic                           Clk,
   input  logic                           Resetn,
   input  logic                           En,
   input  logic [1:0]                     Mode,
   input  logic                           Rot,
   input  logic                           SinL,
   input  logic                           SinR,
   input  logic [WIDTH-1:0]               D,
   output logic [WIDTH-1:0]               Q,
   output logic                           SoutR,
   output logic                           SoutL,
   output logic [$clog2(WIDTH+1)-1:0]     Cnt,
   output logic                           Done
);

   localparam int              CNT_W   = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   // Increment that sticks at WIDTH rather than wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_MAX) begin
         return c;
      end
      return c + CNT_W'(1);
   endfunction

   logic [WIDTH-1:0] q_q,   q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_e            mode;

   assign mode = mode_e'(Mode);

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      if (En) begin
         unique case (mode)
            MODE_HOLD: begin
               q_d   = q_q;
               cnt_d = cnt_q;
            end
            MODE_SHR: begin
               // Rotate feeds the outgoing LSB back into the MSB.
               q_d   = {(Rot ? q_q[0] : SinL), q_q[WIDTH-1:1]};
               cnt_d = sat_inc(cnt_q);
            end
            MODE_SHL: begin
               q_d   = {q_q[WIDTH-2:0], (Rot ? q_q[WIDTH-1] : SinR)};
               cnt_d = sat_inc(cnt_q);
            end
            MODE_LOAD: begin
               q_d   = D;
               cnt_d = '0;
            end
            default: begin
               q_d   = q_q;
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         q_q   <= RESET_VAL;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   // All outputs come from registered state only.
   assign Q     = q_q;
   assign SoutR = q_q[0];
   assign SoutL = q_q[WIDTH-1];
   assign Cnt   = cnt_q;
   assign Done  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          Clk = 1'b0;
   logic          Resetn, En, Rot, SinL, SinR;
   logic [1:0]    Mode;
   logic [W-1:0]  D, Q;
   logic          SoutR, SoutL, Done;
   logic [CW-1:0] Cnt;

   int vectors = 0;
   int miscompares = 0;

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .Clk(Clk), .Resetn(Resetn), .En(En), .Mode(Mode), .Rot(Rot),
      .SinL(SinL), .SinR(SinR), .D(D), .Q(Q), .SoutR(SoutR), .SoutL(SoutL),
      .Cnt(Cnt), .Done(Done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string         name;
      logic          rstn;
      logic          en;
      logic [1:0]    mode;
      logic          rot;
      logic          sinl;
      logic          sinr;
      logic [W-1:0]  d;
      logic [W-1:0]  exp_q;
      logic [CW-1:0] exp_cnt;
      logic          exp_done;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(string name, logic rstn, logic en, logic [1:0] mode,
                               logic rot, logic sinl, logic sinr, logic [W-1:0] d,
                               logic [W-1:0] eq, logic [CW-1:0] ec, logic ed);
      vec_t v;
      v.name = name; v.rstn = rstn; v.en = en; v.mode = mode; v.rot = rot;
      v.sinl = sinl; v.sinr = sinr; v.d = d; v.exp_q = eq; v.exp_cnt = ec;
      v.exp_done = ed;
      tbl.push_back(v);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic rstn, logic en, logic [1:0] mode, logic rot,
                        logic sinl, logic sinr, logic [W-1:0] d);
      Resetn = rstn; En = en; Mode = mode; Rot = rot; SinL = sinl; SinR = sinr; D = d;
   endtask

   task automatic step_check(string name, logic [W-1:0] eq, logic [CW-1:0] ec, logic ed);
      @(posedge Clk);
      #1;
      vectors++;
      chk({name, ".Q"},     64'(Q),     64'(eq));
      chk({name, ".Cnt"},   64'(Cnt),   64'(ec));
      chk({name, ".Done"},  64'(Done),  64'(ed));
      chk({name, ".SoutR"}, 64'(SoutR), 64'(eq[0]));
      chk({name, ".SoutL"}, 64'(SoutL), 64'(eq[W-1]));
   endtask

   initial begin
      logic [W-1:0] q;
      logic [W-1:0] exp_sr;

      // Reset with load request and D=FF present: reset wins.
      add("rst_over_load", 0, 1, 2'b11, 0, 0, 0, 8'hFF, 8'h00, 0, 0);
      // Rotate-left of 81.
      add("ld81",  1, 1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 0, 0);
      add("rl1",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'h03, 1, 0);
      add("rl2",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'h06, 2, 0);
      add("rl3",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'h0C, 3, 0);
      add("rl4",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'h18, 4, 0);
      add("rl5",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'h30, 5, 0);
      add("rl6",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'h60, 6, 0);
      add("rl7",   1, 1, 2'b10, 1, 0, 0, 8'h00, 8'hC0, 7, 0);
      add("rl8",   1, 1, 2'b10, 1, 1, 1, 8'h00, 8'h81, 8, 1);
      // Enable low blocks shifts and loads.
      add("ld3C",  1, 1, 2'b11, 0, 0, 0, 8'h3C, 8'h3C, 0, 0);
      for (int i = 0; i < 5; i++)
         add("en0",  1, 0, 2'b01, 0, 1, 1, 8'h00, 8'h3C, 0, 0);
      add("en0ld", 1, 0, 2'b11, 0, 0, 0, 8'hAA, 8'h3C, 0, 0);
      // Left shift with SinR=1, saturating count.
      add("ld00",  1, 1, 2'b11, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      q = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         q = {q[W-2:0], 1'b1};
         add("sl1", 1, 1, 2'b10, 0, 0, 1, 8'h00, q, (i > 8) ? 4'd8 : 4'(i), (i >= 8));
      end
      add("hold_sat", 1, 1, 2'b00, 0, 0, 0, 8'h55, 8'hFF, 8, 1);
      add("ld12",  1, 1, 2'b11, 1, 1, 1, 8'h12, 8'h12, 0, 0);
      // Right shifts then reset mid-sequence (reset ignores En=0).
      add("ldF0",  1, 1, 2'b11, 0, 0, 0, 8'hF0, 8'hF0, 0, 0);
      add("sr1",   1, 1, 2'b01, 0, 0, 0, 8'h00, 8'h78, 1, 0);
      add("sr2",   1, 1, 2'b01, 0, 0, 0, 8'h00, 8'h3C, 2, 0);
      add("sr3",   1, 1, 2'b01, 0, 0, 0, 8'h00, 8'h1E, 3, 0);
      add("rst_mid", 0, 0, 2'b01, 0, 1, 1, 8'hFF, 8'h00, 0, 0);
      add("sr_after", 1, 1, 2'b01, 0, 1, 0, 8'h00, 8'h80, 1, 0);
      // Hold mode, direction change keeps count, rotate right.
      add("hold",  1, 1, 2'b00, 1, 1, 1, 8'hFF, 8'h80, 1, 0);
      add("sl_dir",1, 1, 2'b10, 0, 1, 0, 8'h00, 8'h00, 2, 0);
      add("ld01",  1, 1, 2'b11, 0, 0, 0, 8'h01, 8'h01, 0, 0);
      add("rr1",   1, 1, 2'b01, 1, 0, 0, 8'h00, 8'h80, 1, 0);
      add("rr2",   1, 1, 2'b01, 1, 1, 0, 8'h00, 8'h40, 2, 0);
      add("sl_sin0", 1, 1, 2'b10, 0, 0, 1, 8'h00, 8'h81, 3, 0);

      drive(0, 1, 2'b11, 0, 0, 0, 8'hFF);
      #2;
      foreach (tbl[i]) begin
         drive(tbl[i].rstn, tbl[i].en, tbl[i].mode, tbl[i].rot,
               tbl[i].sinl, tbl[i].sinr, tbl[i].d);
         step_check(tbl[i].name, tbl[i].exp_q, tbl[i].exp_cnt, tbl[i].exp_done);
      end

      // Serial-out sequence: load A5, right shift 8x with SinL=0,
      // checking SoutR before each edge.
      drive(1, 1, 2'b11, 0, 0, 0, 8'hA5);
      step_check("ldA5", 8'hA5, 0, 0);
      exp_sr = 8'hA5;
      q = 8'hA5;
      for (int i = 1; i <= 8; i++) begin
         drive(1, 1, 2'b01, 0, 0, 1, 8'hFF);
         #1;
         vectors++;
         chk($sformatf("soutr_pre%0d", i), 64'(SoutR), 64'(exp_sr[i-1]));
         q = {1'b0, q[W-1:1]};
         step_check($sformatf("srA5_%0d", i), q, 4'(i), (i == 8));
      end

      // Reset after saturation clears Done; first edge after reset
      // starts from RESET_VAL.
      drive(0, 1, 2'b10, 0, 0, 1, 8'h00);
      step_check("rst_sat", 8'h00, 0, 0);
      drive(1, 1, 2'b10, 0, 0, 1, 8'h00);
      step_check("post_rst_sl", 8'h01, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter: RESET_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Resetn  input  1  synchronous, active-low reset.
REQ-005 En  input  1  clock enable; when 0, all state holds.
REQ-006 Mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Rot  input  1  when 1, shifts rotate (end-around) instead of taking serial-in.
REQ-008 SinL  input  1  serial-in entering the MSB on a right shift.
REQ-009 SinR  input  1  serial-in entering the LSB on a left shift.
REQ-010 D  input  WIDTH  parallel load data.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 SoutR  output  1  combinational copy of Q[0].
REQ-013 SoutL  output  1  combinational copy of Q[WIDTH-1].
REQ-014 Cnt  output  clog2(WIDTH+1)  number of shifts since the last load or reset, saturating.
REQ-015 Done  output  1  high when Cnt equals WIDTH.

Function
REQ-016 Priority at each rising Clk: Resetn=0 first, then En=0 (hold), then Mode.
REQ-017 Mode 00 (hold): Q and Cnt unchanged.
REQ-018 Mode 01, Rot=0: Q <= {SinL, Q[WIDTH-1:1]}.
REQ-019 Mode 01, Rot=1: Q <= {Q[0], Q[WIDTH-1:1]}; SinL ignored.
REQ-020 Mode 10, Rot=0: Q <= {Q[WIDTH-2:0], SinR}.
REQ-021 Mode 10, Rot=1: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; SinR ignored.
REQ-022 Mode 11: Q <= D, Cnt <= 0, in the same edge; Rot, SinL and SinR are ignored.
REQ-023 Latency: every Q change is visible one edge after the controlling inputs are sampled; no combinational path from D, SinL or SinR to Q.
REQ-024 Each enabled shift (Mode 01 or 10) increments Cnt by 1; Cnt saturates at WIDTH, with no wrap to 0.
REQ-025 Shifts after saturation still move Q; only Cnt stays at WIDTH.
REQ-026 A direction change mid-sequence does not clear Cnt; only a load or reset clears it.
REQ-027 Done is derived combinationally from the registered Cnt (Cnt == WIDTH) and has no separate state.
REQ-028 SoutR and SoutL reflect the current Q; they change only after a Q update.
REQ-029 All inputs are sampled only at the rising Clk edge; between edges, outputs depend only on registered state.

Reset
REQ-030 Resetn=0 at a rising edge sets Q=RESET_VAL, Cnt=0 and Done=0, regardless of En, Mode, D, SinL, SinR or Rot.
REQ-031 Reset asserted in the middle of a shift sequence abandons the sequence; the first enabled edge after Resetn returns to 1 operates on RESET_VAL with Cnt=0.
REQ-032 Before the first reset edge, Q and Cnt are undefined; the bench does not check them.

Verification (WIDTH=8, RESET_VAL=0)
REQ-033 Resetn=0, En=1, Mode=11, D=FF, one edge -> Q=00, Cnt=0, Done=0.
REQ-034 Load A5, then 8 edges of Mode=01 with Rot=0 and SinL=0 -> SoutR before each edge reads 1,0,1,0,0,1,0,1; final Q=00, Cnt=8, Done=1.
REQ-035 Load 81, then Mode=10 with Rot=1 -> after 1 edge Q=03, Cnt=1; after 8 edges Q=81, Done=1.
REQ-036 Load 3C, then En=0 with Mode=01 for 5 edges -> Q=3C, Cnt=0 throughout.
REQ-037 Load 00, then 10 edges of Mode=10 with SinR=1 -> Q=FF, Cnt stays at 8 from edge 8 onward; a following load of 12 -> Q=12, Cnt=0, Done=0.
REQ-038 Load F0, then 3 right shifts, then Resetn=0 for one edge -> Q=00, Cnt=0; the next Mode=01 edge with SinL=1 gives Q=80, Cnt=1.
